// File: rtl/ex_stage.sv
// ex_stage -- execute stage of the 5-stage pipeline.
//
// Resolves operand forwarding from EX/MEM and MEM/WB, evaluates the
// single-cycle ALU and runs a sequential multiply/divide engine with HI/LO.
// While a multiply/divide is in flight the stage stalls the front end and
// turns its own outputs into a bubble.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   *_in controls                     ID/EX control fields
//   ALUsrc_in, ALUop_in               B-operand select and ALU class
//   instruction_in                    opcode / shamt / funct source
//   Read_Data_1_in, Read_Data_2_in    register-file operands (rs, rt)
//   Sign_ext_in                       sign-extended immediate
//   Rs_in, Rt_in, Rd_in               register numbers
//   EX_MEM_*, MEM_WB_*                forwarding sources
//   ALU_result_out, Write_Data_out    result and store data to EX/MEM
//   Write_Reg_out                     destination register
//   RegWrite_out .. jump_out          controls to EX/MEM (bubbled on stall)
//   stall_out                         hold PC, IF/ID and ID/EX
//   md_busy_out                       multiply/divide engine not idle
module ex_stage #(
  parameter int MD_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWrite_in,
  input  logic        RegDst_in,
  input  logic        jump_in,
  input  logic        MemToReg_in,
  input  logic        Mem_Write_in,
  input  logic        Mem_Read_in,
  input  logic [1:0]  ALUsrc_in,
  input  logic [1:0]  ALUop_in,
  input  logic [31:0] instruction_in,
  input  logic [31:0] Read_Data_1_in,
  input  logic [31:0] Read_Data_2_in,
  input  logic [31:0] Sign_ext_in,
  input  logic [4:0]  Rs_in,
  input  logic [4:0]  Rt_in,
  input  logic [4:0]  Rd_in,
  input  logic        EX_MEM_RegWrite,
  input  logic        MEM_WB_RegWrite,
  input  logic [4:0]  EX_MEM_Rd,
  input  logic [4:0]  MEM_WB_Rd,
  input  logic [31:0] EX_MEM_result,
  input  logic [31:0] MEM_WB_data,
  output logic [31:0] ALU_result_out,
  output logic [31:0] Write_Data_out,
  output logic [4:0]  Write_Reg_out,
  output logic        RegWrite_out,
  output logic        MemToReg_out,
  output logic        Mem_Write_out,
  output logic        Mem_Read_out,
  output logic        jump_out,
  output logic        stall_out,
  output logic        md_busy_out
);

  localparam int DATA_W = 32;
  localparam int CNT_W  = $clog2(MD_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MD_CYCLES - 1);

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_MFHI = 6'h10;
  localparam logic [5:0] F_MFLO = 6'h12;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  localparam logic [5:0] OP_SLTI = 6'h0A;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_XORI = 6'h0E;

  typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_t;

  // Magnitude of a possibly-signed operand; 0x80000000 maps to 2^31.
  function automatic logic [DATA_W-1:0] mag32(input logic [DATA_W-1:0] v,
                                              input logic is_signed);
    return (is_signed && v[DATA_W-1]) ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [DATA_W-1:0] neg32_if(input logic [DATA_W-1:0] v,
                                                 input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [2*DATA_W-1:0] neg64_if(input logic [2*DATA_W-1:0] v,
                                                   input logic neg);
    return neg ? (~v + 64'd1) : v;
  endfunction

  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic [4:0]         shamt;
  logic               unused_instr;

  logic               ex_hit_rs, wb_hit_rs, ex_hit_rt, wb_hit_rt;
  logic signed [31:0] fwd_rs, fwd_rt;
  logic signed [31:0] op_a, op_b, alu_res;

  logic               md_op;
  logic               lat_signed, lat_div;
  logic [31:0]        a_mag, b_mag;

  md_state_t          md_state, md_state_nx;
  logic [CNT_W-1:0]   md_cnt;
  logic               md_last;
  logic               stall;

  logic [31:0]        hi_q, lo_q;
  logic [31:0]        wk_hi, wk_lo, wk_m, wk_dividend;
  logic               wk_div, wk_neg_q, wk_neg_r, wk_div0;

  logic [32:0]        mul_sum, div_shift;
  logic               div_ge;
  logic [31:0]        div_diff, step_hi, step_lo;
  logic [63:0]        prod;
  logic [31:0]        fin_hi, fin_lo;

  assign opcode       = instruction_in[31:26];
  assign funct        = instruction_in[5:0];
  assign shamt        = instruction_in[10:6];
  assign unused_instr = ^instruction_in[25:16];

  // Operand forwarding: EX/MEM wins over MEM/WB; $zero is never forwarded.
  assign ex_hit_rs = EX_MEM_RegWrite && (EX_MEM_Rd != 5'd0) && (EX_MEM_Rd == Rs_in);
  assign wb_hit_rs = MEM_WB_RegWrite && (MEM_WB_Rd != 5'd0) && (MEM_WB_Rd == Rs_in);
  assign ex_hit_rt = EX_MEM_RegWrite && (EX_MEM_Rd != 5'd0) && (EX_MEM_Rd == Rt_in);
  assign wb_hit_rt = MEM_WB_RegWrite && (MEM_WB_Rd != 5'd0) && (MEM_WB_Rd == Rt_in);

  always_comb begin
    fwd_rs = Read_Data_1_in;
    if (ex_hit_rs)      fwd_rs = EX_MEM_result;
    else if (wb_hit_rs) fwd_rs = MEM_WB_data;

    fwd_rt = Read_Data_2_in;
    if (ex_hit_rt)      fwd_rt = EX_MEM_result;
    else if (wb_hit_rt) fwd_rt = MEM_WB_data;
  end

  always_comb begin
    op_a = fwd_rs;
    case (ALUsrc_in)
      2'b00:   op_b = fwd_rt;
      2'b01:   op_b = Sign_ext_in;
      2'b10:   op_b = {16'h0000, instruction_in[15:0]};
      default: op_b = {instruction_in[15:0], 16'h0000};
    endcase
  end

  // Single-cycle ALU.
  always_comb begin
    alu_res = '0;
    case (ALUop_in)
      2'b00: alu_res = op_a + op_b;
      2'b01: alu_res = op_a - op_b;
      2'b11: begin
        case (opcode)
          OP_ANDI: alu_res = op_a & op_b;
          OP_ORI:  alu_res = op_a | op_b;
          OP_XORI: alu_res = op_a ^ op_b;
          OP_SLTI: alu_res = {31'd0, (op_a < op_b)};
          default: alu_res = op_a + op_b;
        endcase
      end
      default: begin
        case (funct)
          F_ADD, F_ADDU: alu_res = op_a + op_b;
          F_SUB, F_SUBU: alu_res = op_a - op_b;
          F_AND:  alu_res = op_a & op_b;
          F_OR:   alu_res = op_a | op_b;
          F_XOR:  alu_res = op_a ^ op_b;
          F_NOR:  alu_res = ~(op_a | op_b);
          F_SLT:  alu_res = {31'd0, (op_a < op_b)};
          F_SLTU: alu_res = {31'd0, ($unsigned(op_a) < $unsigned(op_b))};
          F_SLL:  alu_res = op_b << shamt;
          F_SRL:  alu_res = $unsigned(op_b) >> shamt;
          F_SRA:  alu_res = op_b >>> shamt;
          F_MFHI: alu_res = hi_q;
          F_MFLO: alu_res = lo_q;
          default: alu_res = '0;   // includes mult/multu/div/divu
        endcase
      end
    endcase
  end

  // funct 0x18..0x1B: bit 1 selects divide, bit 0 selects unsigned.
  assign md_op      = (ALUop_in == 2'b10) && (funct[5:2] == 4'b0110);
  assign lat_div    = funct[1];
  assign lat_signed = ~funct[0];
  assign a_mag      = mag32(fwd_rs, lat_signed);
  assign b_mag      = mag32(fwd_rt, lat_signed);
  assign md_last    = (md_cnt == LAST_STEP);

  // Mult/div FSM: state register.
  always_ff @(posedge clk) begin
    if (rst) md_state <= MD_IDLE;
    else     md_state <= md_state_nx;
  end

  // Mult/div FSM: next state. DONE always returns to IDLE so the same
  // instruction, still sitting in EX for that cycle, cannot re-trigger.
  always_comb begin
    md_state_nx = md_state;
    case (md_state)
      MD_IDLE: if (md_op) md_state_nx = MD_BUSY;
      MD_BUSY: if (md_last) md_state_nx = MD_DONE;
      default: md_state_nx = MD_IDLE;
    endcase
  end

  // Mult/div FSM: outputs. Stall starts combinationally in the issue cycle;
  // BUSY stalls everything, which also holds an mfhi/mflo until results land.
  always_comb begin
    stall       = 1'b0;
    md_busy_out = 1'b0;
    if (!rst) begin
      md_busy_out = (md_state != MD_IDLE);
      case (md_state)
        MD_IDLE: stall = md_op;
        MD_BUSY: stall = 1'b1;
        default: stall = 1'b0;
      endcase
    end
  end

  // One iteration: multiply is shift-add with the multiplier in wk_lo and
  // the partial product growing down from wk_hi; divide is restoring with
  // the remainder in wk_hi and quotient bits shifting into wk_lo.
  always_comb begin
    mul_sum   = {1'b0, wk_hi} + (wk_lo[0] ? {1'b0, wk_m} : 33'd0);
    div_shift = {wk_hi, wk_lo[31]};
    div_ge    = (div_shift >= {1'b0, wk_m});
    // remainder < divisor, so the difference always fits in 32 bits
    div_diff  = div_shift[31:0] - wk_m;
    if (wk_div) begin
      step_hi = div_ge ? div_diff : div_shift[31:0];
      step_lo = {wk_lo[30:0], div_ge};
    end else begin
      step_hi = mul_sum[32:1];
      step_lo = {mul_sum[0], wk_lo[31:1]};
    end
  end

  // Sign fix-up after the final step: quotient and product take the XOR of
  // operand signs, remainder takes the dividend's sign (truncating divide).
  always_comb begin
    prod   = neg64_if({step_hi, step_lo}, wk_neg_q);
    fin_hi = prod[63:32];
    fin_lo = prod[31:0];
    if (wk_div) begin
      if (wk_div0) begin
        fin_hi = wk_dividend;
        fin_lo = '1;
      end else begin
        fin_hi = neg32_if(step_hi, wk_neg_r);
        fin_lo = neg32_if(step_lo, wk_neg_q);
      end
    end
  end

  // Mult/div datapath and HI/LO. Reset aborts any operation without
  // committing a partial result.
  always_ff @(posedge clk) begin
    if (rst) begin
      md_cnt      <= '0;
      wk_hi       <= '0;
      wk_lo       <= '0;
      wk_m        <= '0;
      wk_dividend <= '0;
      wk_div      <= 1'b0;
      wk_neg_q    <= 1'b0;
      wk_neg_r    <= 1'b0;
      wk_div0     <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      case (md_state)
        MD_IDLE: begin
          if (md_op) begin
            md_cnt      <= '0;
            wk_hi       <= '0;
            wk_lo       <= lat_div ? a_mag : b_mag;
            wk_m        <= lat_div ? b_mag : a_mag;
            wk_dividend <= fwd_rs;
            wk_div      <= lat_div;
            wk_neg_q    <= lat_signed & (fwd_rs[31] ^ fwd_rt[31]);
            wk_neg_r    <= lat_signed & fwd_rs[31];
            wk_div0     <= lat_div & (fwd_rt == 32'd0);
          end
        end
        MD_BUSY: begin
          wk_hi  <= step_hi;
          wk_lo  <= step_lo;
          md_cnt <= md_cnt + 1'b1;
          if (md_last) begin
            hi_q <= fin_hi;
            lo_q <= fin_lo;
          end
        end
        default: ;
      endcase
    end
  end

  assign ALU_result_out = alu_res;
  assign Write_Data_out = fwd_rt;
  assign Write_Reg_out  = RegDst_in ? Rd_in : Rt_in;
  assign stall_out      = stall;

  // Side-effecting controls are squashed while stalled so a bubble enters MEM.
  assign RegWrite_out  = RegWrite_in  & ~stall;
  assign Mem_Write_out = Mem_Write_in & ~stall;
  assign Mem_Read_out  = Mem_Read_in  & ~stall;
  assign MemToReg_out  = MemToReg_in;
  assign jump_out      = jump_in;

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWrite_in, RegDst_in, jump_in, MemToReg_in, Mem_Write_in, Mem_Read_in;
  logic [1:0]  ALUsrc_in, ALUop_in;
  logic [31:0] instruction_in, Read_Data_1_in, Read_Data_2_in, Sign_ext_in;
  logic [4:0]  Rs_in, Rt_in, Rd_in;
  logic        EX_MEM_RegWrite, MEM_WB_RegWrite;
  logic [4:0]  EX_MEM_Rd, MEM_WB_Rd;
  logic [31:0] EX_MEM_result, MEM_WB_data;
  logic [31:0] ALU_result_out, Write_Data_out;
  logic [4:0]  Write_Reg_out;
  logic        RegWrite_out, MemToReg_out, Mem_Write_out, Mem_Read_out, jump_out;
  logic        stall_out, md_busy_out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ex_stage #(.MD_CYCLES(32)) dut (
    .clk(clk), .rst(rst),
    .RegWrite_in(RegWrite_in), .RegDst_in(RegDst_in), .jump_in(jump_in),
    .MemToReg_in(MemToReg_in), .Mem_Write_in(Mem_Write_in), .Mem_Read_in(Mem_Read_in),
    .ALUsrc_in(ALUsrc_in), .ALUop_in(ALUop_in), .instruction_in(instruction_in),
    .Read_Data_1_in(Read_Data_1_in), .Read_Data_2_in(Read_Data_2_in),
    .Sign_ext_in(Sign_ext_in), .Rs_in(Rs_in), .Rt_in(Rt_in), .Rd_in(Rd_in),
    .EX_MEM_RegWrite(EX_MEM_RegWrite), .MEM_WB_RegWrite(MEM_WB_RegWrite),
    .EX_MEM_Rd(EX_MEM_Rd), .MEM_WB_Rd(MEM_WB_Rd),
    .EX_MEM_result(EX_MEM_result), .MEM_WB_data(MEM_WB_data),
    .ALU_result_out(ALU_result_out), .Write_Data_out(Write_Data_out),
    .Write_Reg_out(Write_Reg_out), .RegWrite_out(RegWrite_out),
    .MemToReg_out(MemToReg_out), .Mem_Write_out(Mem_Write_out),
    .Mem_Read_out(Mem_Read_out), .jump_out(jump_out),
    .stall_out(stall_out), .md_busy_out(md_busy_out)
  );

  function automatic logic [31:0] rtype(input logic [4:0] sh, input logic [5:0] fn);
    return {6'h00, 15'h0000, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [15:0] imm);
    return {op, 10'h000, imm};
  endfunction

  task automatic clear_inputs();
    RegWrite_in = 0; RegDst_in = 0; jump_in = 0; MemToReg_in = 0;
    Mem_Write_in = 0; Mem_Read_in = 0; ALUsrc_in = 2'b00; ALUop_in = 2'b00;
    instruction_in = rtype(5'd0, 6'h00);
    Read_Data_1_in = 0; Read_Data_2_in = 0; Sign_ext_in = 0;
    Rs_in = 0; Rt_in = 0; Rd_in = 0;
    EX_MEM_RegWrite = 0; MEM_WB_RegWrite = 0; EX_MEM_Rd = 0; MEM_WB_Rd = 0;
    EX_MEM_result = 0; MEM_WB_data = 0;
  endtask

  // Issues a mult/div at cycle T and returns what was observed: stall-high
  // cycle count, busy cycles seen while stalled, bubble violations, HI read
  // in the first unstalled cycle, LO read one cycle later.
  task automatic do_md(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                       output int cyc, output int busy_cyc, output bit bubble_bad,
                       output logic [31:0] hi, output logic [31:0] lo,
                       output logic stall_after);
    @(posedge clk); #1;
    clear_inputs();
    ALUop_in = 2'b10; instruction_in = rtype(5'd0, fn);
    Rs_in = 5'd1; Rt_in = 5'd2; Read_Data_1_in = a; Read_Data_2_in = b;
    RegWrite_in = 1; Mem_Write_in = 1; Mem_Read_in = 1;
    #1;
    cyc = 0; busy_cyc = 0; bubble_bad = 0;
    while (stall_out === 1'b1 && cyc < 40) begin
      cyc++;
      if (md_busy_out === 1'b1) busy_cyc++;
      if (RegWrite_out !== 1'b0 || Mem_Write_out !== 1'b0 || Mem_Read_out !== 1'b0)
        bubble_bad = 1;
      @(posedge clk); #2;
    end
    instruction_in = rtype(5'd0, 6'h10);
    #1;
    hi = ALU_result_out;
    @(posedge clk); #1;
    instruction_in = rtype(5'd0, 6'h12);
    #1;
    lo = ALU_result_out;
    stall_after = stall_out;
    clear_inputs();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    ALUop_in = 2'b10; instruction_in = rtype(5'd0, 6'h18);
    @(posedge clk); #1;
    checks++;
    if (stall_out !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall_out); end
    checks++;
    if (md_busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", md_busy_out); end
    @(posedge clk); #1;
    rst = 0;
    instruction_in = rtype(5'd0, 6'h10);
    #1;
    checks++;
    if (ALU_result_out !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 0", ALU_result_out); end
    instruction_in = rtype(5'd0, 6'h12);
    #1;
    checks++;
    if (ALU_result_out !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 0", ALU_result_out); end
    checks++;
    if (stall_out !== 1'b0 || md_busy_out !== 1'b0) begin
      errors++; $display("FAIL reset_idle: got stall=%b busy=%b want 0/0", stall_out, md_busy_out);
    end
  endtask

  task automatic test_forwarding();
    @(posedge clk); #1;
    clear_inputs();
    ALUop_in = 2'b00; ALUsrc_in = 2'b01; Sign_ext_in = 32'd4;
    Rs_in = 5'd5; Read_Data_1_in = 32'h100;
    Rt_in = 5'd5; Read_Data_2_in = 32'h200; Rd_in = 5'd9;
    EX_MEM_RegWrite = 1; EX_MEM_Rd = 5'd5; EX_MEM_result = 32'h11;
    MEM_WB_RegWrite = 1; MEM_WB_Rd = 5'd5; MEM_WB_data = 32'h22;
    RegDst_in = 1; RegWrite_in = 1; MemToReg_in = 1; jump_in = 1;
    #1;
    checks++;
    if (ALU_result_out !== 32'h15) begin errors++; $display("FAIL fwd_exmem: got %h want 00000015", ALU_result_out); end
    checks++;
    if (Write_Data_out !== 32'h11) begin errors++; $display("FAIL fwd_store_exmem: got %h want 00000011", Write_Data_out); end
    checks++;
    if (Write_Reg_out !== 5'd9) begin errors++; $display("FAIL regdst_rd: got %0d want 9", Write_Reg_out); end
    checks++;
    if ({RegWrite_out, MemToReg_out, jump_out} !== 3'b111) begin
      errors++; $display("FAIL passthru: got %b want 111", {RegWrite_out, MemToReg_out, jump_out});
    end
    EX_MEM_Rd = 5'd0;
    #1;
    checks++;
    if (ALU_result_out !== 32'h26) begin errors++; $display("FAIL fwd_memwb: got %h want 00000026", ALU_result_out); end
    checks++;
    if (Write_Data_out !== 32'h22) begin errors++; $display("FAIL fwd_store_memwb: got %h want 00000022", Write_Data_out); end
    MEM_WB_RegWrite = 0; RegDst_in = 0;
    #1;
    checks++;
    if (ALU_result_out !== 32'h104) begin errors++; $display("FAIL fwd_none: got %h want 00000104", ALU_result_out); end
    checks++;
    if (Write_Reg_out !== 5'd5) begin errors++; $display("FAIL regdst_rt: got %0d want 5", Write_Reg_out); end
  endtask

  task automatic test_alu();
    @(posedge clk); #1;
    clear_inputs();
    ALUop_in = 2'b10; instruction_in = rtype(5'd4, 6'h03);
    Read_Data_2_in = 32'h8000_0000;
    #1;
    checks++;
    if (ALU_result_out !== 32'hF800_0000) begin errors++; $display("FAIL sra: got %h want f8000000", ALU_result_out); end
    instruction_in = rtype(5'd4, 6'h02);
    #1;
    checks++;
    if (ALU_result_out !== 32'h0800_0000) begin errors++; $display("FAIL srl: got %h want 08000000", ALU_result_out); end
    Read_Data_1_in = 32'd1; Read_Data_2_in = 32'hFFFF_FFFF;
    instruction_in = rtype(5'd0, 6'h2B);
    #1;
    checks++;
    if (ALU_result_out !== 32'd1) begin errors++; $display("FAIL sltu: got %h want 00000001", ALU_result_out); end
    instruction_in = rtype(5'd0, 6'h2A);
    #1;
    checks++;
    if (ALU_result_out !== 32'd0) begin errors++; $display("FAIL slt: got %h want 00000000", ALU_result_out); end
    Read_Data_1_in = 32'h0F0F_0000; Read_Data_2_in = 32'h00FF_00FF;
    instruction_in = rtype(5'd0, 6'h27);
    #1;
    checks++;
    if (ALU_result_out !== 32'hF000_FF00) begin errors++; $display("FAIL nor: got %h want f000ff00", ALU_result_out); end
    instruction_in = rtype(5'd0, 6'h23);
    #1;
    checks++;
    if (ALU_result_out !== 32'h0E0F_FF01) begin errors++; $display("FAIL subu: got %h want 0e0fff01", ALU_result_out); end
    instruction_in = rtype(5'd0, 6'h3F);
    #1;
    checks++;
    if (ALU_result_out !== 32'd0) begin errors++; $display("FAIL bad_funct: got %h want 00000000", ALU_result_out); end
    ALUop_in = 2'b11; ALUsrc_in = 2'b11; Read_Data_1_in = 32'd0;
    instruction_in = itype(6'h0F, 16'h1234);
    #1;
    checks++;
    if (ALU_result_out !== 32'h1234_0000) begin errors++; $display("FAIL lui: got %h want 12340000", ALU_result_out); end
    ALUsrc_in = 2'b10; Read_Data_1_in = 32'h0000_00F0;
    instruction_in = itype(6'h0D, 16'h8001);
    #1;
    checks++;
    if (ALU_result_out !== 32'h0000_80F1) begin errors++; $display("FAIL ori_zext: got %h want 000080f1", ALU_result_out); end
    ALUop_in = 2'b01; ALUsrc_in = 2'b00; Read_Data_1_in = 32'd3; Read_Data_2_in = 32'd5;
    #1;
    checks++;
    if (ALU_result_out !== 32'hFFFF_FFFE) begin errors++; $display("FAIL beq_sub: got %h want fffffffe", ALU_result_out); end
  endtask

  task automatic test_mult();
    int cyc, busy_cyc; bit bub; logic [31:0] hi, lo; logic st;
    do_md(6'h18, 32'hFFFF_FFFD, 32'd7, cyc, busy_cyc, bub, hi, lo, st);
    checks++;
    if (cyc != 33) begin errors++; $display("FAIL mult_stall_cycles: got %0d want 33", cyc); end
    checks++;
    if (busy_cyc != 32) begin errors++; $display("FAIL mult_busy_cycles: got %0d want 32", busy_cyc); end
    checks++;
    if (bub) begin errors++; $display("FAIL mult_bubble: got controls active while stalled want none"); end
    checks++;
    if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
    checks++;
    if (lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_lo: got %h want ffffffeb", lo); end
    checks++;
    if (st !== 1'b0) begin errors++; $display("FAIL mult_no_retrigger: got stall=%b want 0", st); end
  endtask

  task automatic test_div();
    int cyc, busy_cyc; bit bub; logic [31:0] hi, lo; logic st;
    do_md(6'h1B, 32'd100, 32'd7, cyc, busy_cyc, bub, hi, lo, st);
    checks++;
    if (cyc != 33) begin errors++; $display("FAIL divu_stall_cycles: got %0d want 33", cyc); end
    checks++;
    if (lo !== 32'd14 || hi !== 32'd2) begin errors++; $display("FAIL divu: got hi=%h lo=%h want hi=00000002 lo=0000000e", hi, lo); end
    do_md(6'h1A, 32'hFFFF_FFF9, 32'd2, cyc, busy_cyc, bub, hi, lo, st);
    checks++;
    if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL div_signed: got hi=%h lo=%h want hi=ffffffff lo=fffffffd", hi, lo);
    end
    do_md(6'h18, 32'h8000_0000, 32'd2, cyc, busy_cyc, bub, hi, lo, st);
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'h0) begin
      errors++; $display("FAIL mult_minint: got hi=%h lo=%h want hi=ffffffff lo=00000000", hi, lo);
    end
    do_md(6'h1A, 32'd9, 32'd0, cyc, busy_cyc, bub, hi, lo, st);
    checks++;
    if (cyc != 33) begin errors++; $display("FAIL div0_stall_cycles: got %0d want 33", cyc); end
    checks++;
    if (hi !== 32'd9 || lo !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL div0: got hi=%h lo=%h want hi=00000009 lo=ffffffff", hi, lo);
    end
  endtask

  task automatic test_mflo_interlock();
    int cyc; logic il_stall;
    @(posedge clk); #1;
    clear_inputs();
    ALUop_in = 2'b10; instruction_in = rtype(5'd0, 6'h19);
    Read_Data_1_in = 32'd6; Read_Data_2_in = 32'd7; RegWrite_in = 1;
    #1;
    cyc = 0; il_stall = 1'b0;
    while (stall_out === 1'b1 && cyc < 40) begin
      cyc++;
      @(posedge clk); #1;
      if (cyc == 5) begin
        instruction_in = rtype(5'd0, 6'h12);
        #1;
        il_stall = stall_out;
      end else begin
        #1;
      end
    end
    checks++;
    if (il_stall !== 1'b1) begin errors++; $display("FAIL mflo_interlock: got stall=%b want 1", il_stall); end
    checks++;
    if (cyc != 33) begin errors++; $display("FAIL mflo_stall_cycles: got %0d want 33", cyc); end
    checks++;
    if (ALU_result_out !== 32'd42) begin errors++; $display("FAIL mflo_value: got %h want 0000002a", ALU_result_out); end
    checks++;
    if (md_busy_out !== 1'b1 || RegWrite_out !== 1'b1) begin
      errors++; $display("FAIL mflo_done: got busy=%b regwrite=%b want 1/1", md_busy_out, RegWrite_out);
    end
    @(posedge clk); #2;
    checks++;
    if (stall_out !== 1'b0 || md_busy_out !== 1'b0) begin
      errors++; $display("FAIL mflo_after: got stall=%b busy=%b want 0/0", stall_out, md_busy_out);
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_op();
    @(posedge clk); #1;
    clear_inputs();
    ALUop_in = 2'b10; instruction_in = rtype(5'd0, 6'h18);
    Read_Data_1_in = 32'd5; Read_Data_2_in = 32'd5;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (md_busy_out !== 1'b1) begin errors++; $display("FAIL midop_busy: got %b want 1", md_busy_out); end
    rst = 1;
    #1;
    checks++;
    if (stall_out !== 1'b0 || md_busy_out !== 1'b0) begin
      errors++; $display("FAIL midop_in_reset: got stall=%b busy=%b want 0/0", stall_out, md_busy_out);
    end
    @(posedge clk); #1;
    rst = 0;
    instruction_in = rtype(5'd0, 6'h10);
    #1;
    checks++;
    if (stall_out !== 1'b0 || md_busy_out !== 1'b0) begin
      errors++; $display("FAIL midop_after: got stall=%b busy=%b want 0/0", stall_out, md_busy_out);
    end
    checks++;
    if (ALU_result_out !== 32'h0) begin errors++; $display("FAIL midop_hi: got %h want 00000000", ALU_result_out); end
    instruction_in = rtype(5'd0, 6'h12);
    #1;
    checks++;
    if (ALU_result_out !== 32'h0) begin errors++; $display("FAIL midop_lo: got %h want 00000000", ALU_result_out); end
    clear_inputs();
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    test_reset();
    test_forwarding();
    test_alu();
    test_mult();
    test_div();
    test_mflo_interlock();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage. Consumes the fields latched by the ID/EX pipeline register and produces the ALU result, store data, destination register and pass-through controls for the EX/MEM register.
- Contains operand forwarding muxes, a single-cycle ALU, and a 32-iteration sequential multiply/divide unit with HI/LO registers.
- Asserts a stall to the hazard unit while a multi-cycle operation is in progress.

Parameters:
- MD_CYCLES, 32, iterations of the mult/div engine (datapath width fixed at 32).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- RegWrite_in, RegDst_in, jump_in, MemToReg_in, Mem_Write_in, Mem_Read_in  in  1 each  controls from ID/EX
- ALUsrc_in  in  2  B-operand select
- ALUop_in  in  2  ALU class
- instruction_in  in  32  instruction; uses opcode, shamt and funct
- Read_Data_1_in, Read_Data_2_in, Sign_ext_in  in  32 each  register operands and sign-extended immediate
- Rs_in, Rt_in, Rd_in  in  5 each  register numbers
- EX_MEM_RegWrite, MEM_WB_RegWrite  in  1 each  forwarding-source write enables
- EX_MEM_Rd, MEM_WB_Rd  in  5 each  forwarding-source destinations
- EX_MEM_result, MEM_WB_data  in  32 each  forwarding-source values
- ALU_result_out  out  32  result to EX/MEM
- Write_Data_out  out  32  forwarded rt value, used as store data
- Write_Reg_out  out  5  RegDst_in ? Rd_in : Rt_in
- RegWrite_out, MemToReg_out, Mem_Write_out, Mem_Read_out, jump_out  out  1 each  pass-through controls
- stall_out  out  1  hold PC, IF/ID and ID/EX
- md_busy_out  out  1  mult/div engine not IDLE

Behaviour:
- Clocking and reset: one clock `clk`; reset `rst` is synchronous and active-high.
  - On reset, the FSM goes to IDLE and HI, LO, the counter and the working registers clear to 0.
  - During reset, stall_out and md_busy_out are 0.
  - All other outputs are combinational from the inputs and HI/LO.
- Forwarding (operand A uses Rs, operand B and store data use Rt):
  - Take EX_MEM_result if EX_MEM_RegWrite and EX_MEM_Rd == Rs (or Rt) and EX_MEM_Rd != 0.
  - Otherwise take MEM_WB_data under the same rule with the MEM_WB inputs.
  - Otherwise take Read_Data_1_in / Read_Data_2_in.
  - EX/MEM has priority over MEM/WB.
- B-operand select (ALUsrc_in):
  - 00: forwarded rt
  - 01: Sign_ext_in
  - 10: zero-extend of instr[15:0]
  - 11: {instr[15:0], 16'h0} (lui)
- ALUop_in 00: add (lw/sw address).
- ALUop_in 01: sub (beq).
- ALUop_in 11: decode opcode instr[31:26]:
  - 0x0C and, 0x0D or, 0x0E xor, 0x0A slt; anything else is add.
- ALUop_in 10: decode funct instr[5:0]:
  - 0x20/0x21 add
  - 0x22/0x23 sub
  - 0x24 and, 0x25 or, 0x26 xor, 0x27 nor
  - 0x2A slt (signed), 0x2B sltu
  - 0x00 sll, 0x02 srl, 0x03 sra: shift B by instr[10:6]
  - 0x10 mfhi (result = HI), 0x12 mflo (result = LO)
  - 0x18 mult, 0x19 multu, 0x1A div, 0x1B divu: mult/div ops, ALU_result_out = 0
  - Any other funct gives result 0.
- Arithmetic: all arithmetic is modulo 2^32. There is no overflow trap.
- Mult/div FSM states: IDLE, BUSY, DONE.
  - IDLE:
    - Mult/div op present, not in reset → latch operands, counter = 0, go to BUSY.
    - stall_out = 1 that same cycle (combinational).
  - BUSY:
    - One shift-add / restoring-subtract step per cycle; counter increments.
    - stall_out = 1.
    - After MD_CYCLES steps, write HI/LO and go to DONE.
  - DONE: stall_out = 0 for exactly one cycle, so the op advances. Next state is IDLE unconditionally; no re-trigger on the same instruction.
  - Latency: op enters EX at cycle T; stall_out is high T..T+32; DONE at T+33; HI/LO are visible from T+33.
- Signed ops: operate on magnitudes, then fix signs.
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - mult: {HI,LO} = 64-bit product.
  - div: LO = quotient, HI = remainder.
- Divide by zero (div or divu): HI = dividend, LO = 32'hFFFFFFFF. The op still takes full latency.
- Interlock: mfhi/mflo in EX while the FSM is BUSY → stall_out = 1 until DONE.
- Bubble during stall: whenever stall_out = 1, RegWrite_out, Mem_Write_out and Mem_Read_out are forced 0.
- Reset mid-operation: abort to IDLE; HI/LO = 0; no partial result is written.
- md_busy_out = (state != IDLE).

Test Plan:
- Forwarding priority:
  - Stimulus: Rs = 5, EX_MEM (RegWrite=1, Rd=5, result=0x11), MEM_WB (RegWrite=1, Rd=5, data=0x22), ALUop=00, Sign_ext=4.
  - Response: ALU_result_out = 0x15.
  - Then set EX_MEM_Rd = 0 → ALU_result_out = 0x26.
- R-type/immediate set:
  - sra shamt=4 on 0x80000000 → 0xF8000000.
  - sltu 1 vs 0xFFFFFFFF → 1; slt → 0.
  - ALUsrc=11, imm 0x1234 → 0x12340000.
- mult, signed:
  - Stimulus: mult -3 × 7 at cycle T.
  - Response: stall_out high T..T+32, low at T+33; HI = 0xFFFFFFFF, LO = 0xFFFFFFEB; RegWrite_out = 0 during stall.
- divu and div:
  - divu 100/7 → LO = 14, HI = 2.
  - div -7/2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
  - div by 0 with dividend 9 → HI = 9, LO = 0xFFFFFFFF.
- mflo interlock:
  - Stimulus: mflo presented while BUSY.
  - Response: stalls until DONE; result equals the new LO.
- Reset at T+10 of a mult:
  - Response: next cycle stall_out = 0, md_busy_out = 0, HI = LO = 0.
